// File: rtl/j2c_arbiter.sv
// Round-robin burst arbiter sharing one j2c byte serializer; req->tx_valid 2 cycles, tx_done->next tx_valid 2 cycles.
// Backpressure: tx_ready stalls LOAD with tx_valid/tx_data held; each byte waits for tx_done before the next is fetched.
module j2c_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int MESSAGE_LENGTH = 8,
  parameter int GAP_CYCLES     = 2
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*MESSAGE_LENGTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]                req_last,
  output logic [NUM_REQ-1:0]                req_ack,
  output logic [NUM_REQ-1:0]                grant,
  output logic                              busy,
  output logic                              abort,
  output logic [MESSAGE_LENGTH-1:0]         tx_data,
  output logic                              tx_valid,
  input  logic                              tx_ready,
  input  logic                              tx_done
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, GAP} state_t;

  state_t              state;
  logic [PW-1:0]       g_idx;
  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       rr_next;
  logic [CW-1:0]       gap_cnt;
  logic                last_q;

  logic                win_vld;
  logic [PW-1:0]       win_idx;
  int                  idx;
  logic                g_req;
  logic                g_last;
  logic [MESSAGE_LENGTH-1:0] g_data;
  logic                hs;
  logic                drop;

  // Walk offsets high-to-low so the nearest requester above rr_ptr is the last one written.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = (int'(rr_ptr) + off) % NUM_REQ;
      if (req[idx]) begin
        win_vld = 1'b1;
        win_idx = PW'(idx);
      end
    end
  end

  always_comb begin
    g_req   = req[g_idx];
    g_last  = req_last[g_idx];
    g_data  = req_data[g_idx*MESSAGE_LENGTH +: MESSAGE_LENGTH];
    rr_next = (g_idx == PW'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
    hs      = (state == LOAD) && tx_valid && tx_ready;
    // A handshake in the same cycle as a req drop still completes the byte.
    drop    = (state == LOAD) && !g_req && !hs;
    req_ack = hs ? grant : '0;
    abort   = drop;
    busy    = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      grant    <= '0;
      g_idx    <= '0;
      rr_ptr   <= '0;
      gap_cnt  <= '0;
      last_q   <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            grant          <= '0;
            grant[win_idx] <= 1'b1;
            g_idx          <= win_idx;
            state          <= LOAD;
          end
        end
        LOAD: begin
          if (hs) begin
            tx_valid <= 1'b0;
            last_q   <= g_last;
            state    <= WAIT;
          end else if (drop) begin
            tx_valid <= 1'b0;
            grant    <= '0;
            rr_ptr   <= rr_next;
            gap_cnt  <= '0;
            state    <= GAP;
          end else if (!tx_valid) begin
            tx_data  <= g_data;
            tx_valid <= 1'b1;
          end
        end
        WAIT: begin
          if (tx_done) begin
            if (last_q) begin
              grant   <= '0;
              rr_ptr  <= rr_next;
              gap_cnt <= '0;
              state   <= GAP;
            end else begin
              state <= LOAD;
            end
          end
        end
        GAP: begin
          if (gap_cnt == CW'(GAP_CYCLES - 1)) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_j2c_arbiter.sv
// Directed bench for j2c_arbiter: single byte, round-robin order, burst, stall, abort, async reset mid-WAIT.
module tb_j2c_arbiter;

  logic        clk;
  logic        rstn;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ack;
  logic [3:0]  grant;
  logic        busy;
  logic        abort;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_done;

  j2c_arbiter #(.NUM_REQ(4), .MESSAGE_LENGTH(8), .GAP_CYCLES(2)) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_data(req_data), .req_last(req_last),
    .req_ack(req_ack), .grant(grant), .busy(busy), .abort(abort),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_done(tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Requester model: byte lists walked forward on each req_ack.
  logic [7:0] bytes [4][4];
  logic       lastb [4][4];
  int         len [4];
  int         ptr [4];
  logic       en  [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req[i]            = 1'b0;
      req_last[i]       = 1'b0;
      req_data[i*8 +: 8] = 8'h00;
      if (en[i] && ptr[i] < len[i]) begin
        req[i]             = 1'b1;
        req_last[i]        = lastb[i][ptr[i]];
        req_data[i*8 +: 8] = bytes[i][ptr[i]];
      end
    end
  endtask

  task automatic tick();
    logic [3:0] ack;
    #1;
    ack = req_ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (ack[i]) ptr[i]++;
    drive();
    #1;
  endtask

  task automatic done_pulse();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  // Entered LOAD on the previous edge; runs one byte through to tx_done.
  task automatic xfer(input string tag, input int gi, input logic [7:0] d);
    logic [3:0] g;
    g = 4'b0001 << gi;
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_v0"}, 32'(tx_valid), 32'h0);
    tick();
    chk({tag, "_v1"}, 32'(tx_valid), 32'h1);
    chk({tag, "_data"}, 32'(tx_data), 32'(d));
    chk({tag, "_ack"}, 32'(req_ack), 32'(g));
    tick();
    chk({tag, "_wv"}, 32'(tx_valid), 32'h0);
    chk({tag, "_wack"}, 32'(req_ack), 32'h0);
    chk({tag, "_wgrant"}, 32'(grant), 32'(g));
    tick();
    done_pulse();
  endtask

  // Called in the first GAP cycle; returns in IDLE.
  task automatic gap_then_idle(input string tag);
    chk({tag, "_gap_grant"}, 32'(grant), 32'h0);
    chk({tag, "_gap1_busy"}, 32'(busy), 32'h1);
    tick();
    chk({tag, "_gap2_busy"}, 32'(busy), 32'h1);
    tick();
    chk({tag, "_idle_busy"}, 32'(busy), 32'h0);
    chk({tag, "_idle_abort"}, 32'(abort), 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_txv"}, 32'(tx_valid), 32'h0);
    chk({tag, "_txd"}, 32'(tx_data), 32'h0);
    chk({tag, "_ack"}, 32'(req_ack), 32'h0);
    chk({tag, "_abort"}, 32'(abort), 32'h0);
  endtask

  initial begin
    logic [7:0] rr_exp [5];
    rstn     = 1'b0;
    tx_ready = 1'b0;
    tx_done  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      len[i] = 0;
      ptr[i] = 0;
      en[i]  = 1'b1;
      for (int k = 0; k < 4; k++) begin
        bytes[i][k] = 8'h00;
        lastb[i][k] = 1'b0;
      end
    end
    drive();
    #3;
    check_reset_outputs("por");
    #9 rstn = 1'b1;

    // Single byte from requester 1
    bytes[1][0] = 8'hA5; lastb[1][0] = 1'b1; len[1] = 1; ptr[1] = 0;
    tx_ready = 1'b1;
    drive();
    tick();
    chk("single_busy", 32'(busy), 32'h1);
    xfer("single", 1, 8'hA5);
    gap_then_idle("single");

    // Fresh reset so round-robin starts at requester 0
    #1 rstn = 1'b0;
    #2 rstn = 1'b1;
    bytes[0][0] = 8'h10; lastb[0][0] = 1'b1;
    bytes[0][1] = 8'h50; lastb[0][1] = 1'b1; len[0] = 2; ptr[0] = 0;
    bytes[1][0] = 8'h11; lastb[1][0] = 1'b1; len[1] = 1; ptr[1] = 0;
    bytes[2][0] = 8'h12; lastb[2][0] = 1'b1; len[2] = 1; ptr[2] = 0;
    bytes[3][0] = 8'h13; lastb[3][0] = 1'b1; len[3] = 1; ptr[3] = 0;
    rr_exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h50};
    drive();
    tick();
    for (int k = 0; k < 5; k++) begin
      xfer($sformatf("rr%0d", k), k % 4, rr_exp[k]);
      gap_then_idle($sformatf("rr%0d", k));
      if (k < 4) tick();
    end

    // Three-byte burst from requester 2; requester 0 raises mid-burst
    bytes[2][0] = 8'h11; lastb[2][0] = 1'b0;
    bytes[2][1] = 8'h22; lastb[2][1] = 1'b0;
    bytes[2][2] = 8'h33; lastb[2][2] = 1'b1; len[2] = 3; ptr[2] = 0;
    drive();
    tick();
    bytes[0][0] = 8'hAA; lastb[0][0] = 1'b0;
    bytes[0][1] = 8'hBB; lastb[0][1] = 1'b1; len[0] = 2; ptr[0] = 0;
    drive();
    xfer("burst0", 2, 8'h11);
    chk("burst0_busy", 32'(busy), 32'h1);
    xfer("burst1", 2, 8'h22);
    chk("burst1_busy", 32'(busy), 32'h1);
    xfer("burst2", 2, 8'h33);
    bytes[3][0] = 8'h77; lastb[3][0] = 1'b1; len[3] = 1; ptr[3] = 0;
    tx_ready = 1'b0;
    drive();
    gap_then_idle("burst");

    // Stall: requester 3 wins from rr_ptr=3; stray tx_done in LOAD is ignored
    tick();
    chk("stall_grant", 32'(grant), 32'h8);
    tick();
    chk("stall_v", 32'(tx_valid), 32'h1);
    chk("stall_d", 32'(tx_data), 32'h77);
    chk("stall_ack", 32'(req_ack), 32'h0);
    for (int k = 0; k < 4; k++) begin
      if (k == 1) tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk($sformatf("stall%0d_v", k), 32'(tx_valid), 32'h1);
      chk($sformatf("stall%0d_d", k), 32'(tx_data), 32'h77);
      chk($sformatf("stall%0d_ack", k), 32'(req_ack), 32'h0);
    end
    tx_ready = 1'b1;
    #1;
    chk("stall_release_ack", 32'(req_ack), 32'h8);
    tick();
    chk("stall_wait_v", 32'(tx_valid), 32'h0);
    tick();
    done_pulse();
    gap_then_idle("stall");

    // Abort: requester 0 drops req after its first, non-last byte
    tick();
    xfer("abort_b0", 0, 8'hAA);
    en[0] = 1'b0;
    drive();
    #1;
    chk("abort_pulse", 32'(abort), 32'h1);
    chk("abort_ack", 32'(req_ack), 32'h0);
    chk("abort_txv", 32'(tx_valid), 32'h0);
    tick();
    chk("abort_once", 32'(abort), 32'h0);
    bytes[0][0] = 8'hD0; lastb[0][0] = 1'b1; len[0] = 1; ptr[0] = 0; en[0] = 1'b1;
    bytes[1][0] = 8'hC1; lastb[1][0] = 1'b1; len[1] = 1; ptr[1] = 0;
    drive();
    gap_then_idle("abort");

    // rr_ptr=1 after the abort, then async reset while in WAIT
    tick();
    chk("post_abort_grant", 32'(grant), 32'h2);
    tick();
    chk("rst_pre_d", 32'(tx_data), 32'hC1);
    tick();
    chk("rst_pre_busy", 32'(busy), 32'h1);
    #1 rstn = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    #1 rstn = 1'b1;
    tick();
    xfer("post_rst", 0, 8'hD0);
    gap_then_idle("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/j2c_arbiter.md
# j2c_arbiter

Round-robin arbiter and transaction sequencer that shares one j2c byte serializer between NUM_REQ requesters. Each requester presents bytes with a valid/last handshake. The arbiter grants one requester for a whole burst, feeds its bytes to the serializer one at a time, and waits for each serialization to complete. It enforces a bus-free gap between bursts. It sits between client logic and the serializer's parallel data input.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- MESSAGE_LENGTH, 8, byte width, matches serializer
- GAP_CYCLES, 2, idle cycles between bursts (≥1)

- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester valid; held until acked
- req_data  in  NUM_REQ*MESSAGE_LENGTH  byte of requester i at [i*MESSAGE_LENGTH +: MESSAGE_LENGTH]
- req_last  in  NUM_REQ  marks final byte of burst, qualified by req
- req_ack  out  NUM_REQ  one-cycle pulse: byte of requester i accepted
- grant  out  NUM_REQ  one-hot owner of current burst, 0 when idle
- busy  out  1  high in any state except IDLE
- abort  out  1  one-cycle pulse: burst ended by requester dropping req
- tx_data  out  MESSAGE_LENGTH  byte to serializer, registered
- tx_valid  out  1  byte offered to serializer
- tx_ready  in  1  serializer can accept a byte
- tx_done  in  1  one-cycle pulse: serializer finished current byte

## Operation
- State machine states: IDLE, LOAD, WAIT, GAP.
- IDLE:
  - If any req bit is set, select the winner by searching from rr_ptr upward with wrap.
  - Set grant to the winner. Go to LOAD.
  - If no req bit is set, stay in IDLE.
- LOAD:
  - tx_valid=1. tx_data is driven from the registered copy of the granted requester's data.
  - On tx_valid & tx_ready (handshake):
    - Pulse req_ack[g] in the same cycle.
    - Capture req_last[g] into last_q.
    - Go to WAIT with tx_valid=0 from the next cycle.
  - If req[g] is low while in LOAD: pulse abort and go to GAP.
- WAIT:
  - Hold until tx_done.
  - On tx_done with last_q=1: go to GAP.
  - On tx_done with last_q=0: go to LOAD, so the requester supplies its next byte.
  - tx_done outside WAIT is ignored.
- GAP:
  - gap_cnt counts GAP_CYCLES cycles, then the block goes to IDLE.
  - On entry to GAP: rr_ptr = (g+1) mod NUM_REQ, and grant clears.
- Round-robin:
  - rr_ptr has width clog2(NUM_REQ). It wraps from NUM_REQ-1 to 0.
  - rr_ptr updates only on burst end, whether normal or aborted.
- Grant stability:
  - grant never changes during LOAD or WAIT.
  - New req bits raised mid-burst only compete at the next IDLE.
- Simultaneous events:
  - A tx_ready handshake and a req drop in the same cycle count as a handshake; req_ack wins.
  - tx_done and a new req arrival are independent.
- Reset values: state=IDLE, grant=0, req_ack=0, abort=0, busy=0, tx_valid=0, tx_data=0, rr_ptr=0, gap_cnt=0, last_q=0.
- Reset mid-burst: all outputs drop to reset values asynchronously, and the partially sent byte is abandoned. The serializer is expected to be reset by the same rstn.

## Timing
- req rises before rising edge k in IDLE:
  - grant valid after edge k.
  - tx_valid high after edge k+1 (LOAD entry registers tx_data).
- Latency from req to tx_valid: 2 cycles. Byte-to-byte turnaround after tx_done: 2 cycles to the next tx_valid.
- tx_valid stays high until the handshake. tx_data is stable while tx_valid=1.
- req_ack is asserted only in the handshake cycle. The requester may present the next byte on the following cycle.
- busy is high from the edge that leaves IDLE until the edge that re-enters IDLE.
- GAP length is exactly GAP_CYCLES cycles. For back-to-back bursts, the minimum gap from the last tx_done to the next grant is GAP_CYCLES+1 cycles.
- The abort pulse aligns with the cycle in which LOAD exits to GAP.

## Test plan
- Single byte: req[1]=1, data 0xA5, last=1, tx_ready=1.
  - grant=0010 one cycle later.
  - tx_valid with tx_data=0xA5 two cycles after req.
  - One req_ack[1] pulse.
  - After tx_done: GAP for 2 cycles, then IDLE with busy=0.
- Round-robin: all four req high with single-byte bursts.
  - Grants in order 0,1,2,3,0.
  - rr_ptr wraps to 0.
  - No requester is granted twice before all others are served.
- Burst: requester 2 sends 0x11, 0x22, 0x33, with last on 0x33.
  - Three req_ack pulses and three tx_valid phases.
  - grant=0100 is held throughout.
  - Only one GAP, after the third tx_done.
- Stall: tx_ready=0 for 5 cycles in LOAD.
  - tx_valid and tx_data stay constant.
  - No req_ack until tx_ready=1.
- Abort: requester 0 drops req after its first non-last byte.
  - abort pulses once, with no further req_ack.
  - Block enters GAP and rr_ptr=1.
- Reset mid-WAIT: rstn low asynchronously.
  - All outputs reach reset values immediately, without waiting for a clock edge.
  - After release, the first grant goes to requester 0.
